// File: rtl/sim_top.sv
// SoC stub for the simulation harness: emits a boot message on the byte UART,
// then polls the UART input and echoes every received byte. Every emitted
// byte is reported as one committed step on difftest_step.
//
// Ports:
//   clock, reset (sync, active-low)
//   io_logCtrl_log_begin/end/level : log window control (debug-only log_active)
//   io_perfInfo_clean/dump         : clear / snapshot the perf counters
//   io_uart_out_valid/ch           : one-cycle byte emission strobe + byte
//   io_uart_in_valid, io_uart_in_ch: one-cycle poll request + sampled byte (0xFF = none)
//   difftest_step                  : one-cycle commit strobe, mirrors io_uart_out_valid
module sim_top #(
    parameter int unsigned BOOT_DELAY    = 8,
    parameter int unsigned CHAR_GAP      = 4,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned MSG_LEN       = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] io_logCtrl_log_begin,
    input  logic [63:0] io_logCtrl_log_end,
    input  logic [63:0] io_logCtrl_log_level,
    input  logic        io_perfInfo_clean,
    input  logic        io_perfInfo_dump,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch,
    output logic        difftest_step
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned PERF_W    = 32;
    localparam int unsigned GAP_LAST  = (CHAR_GAP > 1) ? CHAR_GAP - 2 : 0;
    localparam int unsigned POLL_LAST = POLL_INTERVAL - 2;

    typedef enum logic [2:0] {
        BOOT, EMIT, GAP, POLL_WAIT, POLL, ECHO
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic                   out_valid_d, in_valid_d;
    logic [7:0]             out_ch_d;
    logic [63:0]            cycle_cnt;
    logic [PERF_W-1:0]      chars_out, polls;
    logic [PERF_W-1:0]      snap_chars_out, snap_polls;
    logic                   log_active;

    // Boot message ROM: "Hello, World!\n"
    function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] i);
        case (i)
            IDX_W'(0):  rom_byte = 8'h48;
            IDX_W'(1):  rom_byte = 8'h65;
            IDX_W'(2):  rom_byte = 8'h6C;
            IDX_W'(3):  rom_byte = 8'h6C;
            IDX_W'(4):  rom_byte = 8'h6F;
            IDX_W'(5):  rom_byte = 8'h2C;
            IDX_W'(6):  rom_byte = 8'h20;
            IDX_W'(7):  rom_byte = 8'h57;
            IDX_W'(8):  rom_byte = 8'h6F;
            IDX_W'(9):  rom_byte = 8'h72;
            IDX_W'(10): rom_byte = 8'h6C;
            IDX_W'(11): rom_byte = 8'h64;
            IDX_W'(12): rom_byte = 8'h21;
            IDX_W'(13): rom_byte = 8'h0A;
            default:    rom_byte = 8'h00;
        endcase
    endfunction

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= BOOT;
            cnt               <= '0;
            idx               <= '0;
            io_uart_out_valid <= 1'b0;
            io_uart_out_ch    <= 8'h00;
            io_uart_in_valid  <= 1'b0;
            difftest_step     <= 1'b0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            idx               <= idx_d;
            io_uart_out_valid <= out_valid_d;
            io_uart_out_ch    <= out_ch_d;
            io_uart_in_valid  <= in_valid_d;
            difftest_step     <= out_valid_d;
        end
    end

    // Next state; outputs are derived from the next state so they line up with it
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        out_valid_d = 1'b0;
        in_valid_d  = 1'b0;
        out_ch_d    = io_uart_out_ch;

        case (state)
            BOOT: begin
                if (cnt == CNT_W'(BOOT_DELAY)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            EMIT: begin
                cnt_d = '0;
                if (idx == IDX_W'(MSG_LEN - 1)) begin
                    state_d = POLL_WAIT;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = (CHAR_GAP > 1) ? GAP : EMIT;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_LAST)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            POLL_WAIT: begin
                if (cnt == CNT_W'(POLL_LAST)) begin
                    state_d = POLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            POLL: begin
                cnt_d   = '0;
                state_d = (io_uart_in_ch == 8'hFF) ? POLL_WAIT : ECHO;
            end
            ECHO: begin
                cnt_d   = '0;
                state_d = POLL_WAIT;
            end
            default: begin
                state_d = BOOT;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        out_valid_d = (state_d == EMIT) || (state_d == ECHO);
        in_valid_d  = (state_d == POLL);
        if (state_d == EMIT) begin
            out_ch_d = rom_byte(idx_d);
        end else if (state_d == ECHO) begin
            // ECHO is only entered from POLL, so the byte sampled now is the one to echo
            out_ch_d = io_uart_in_ch;
        end
    end

    // Free-running cycle counter and registered log window flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            log_active <= 1'b0;
        end else begin
            cycle_cnt  <= cycle_cnt + 64'd1;
            // Evaluated against the value cycle_cnt takes at this edge
            log_active <= io_logCtrl_log_level[0] && (io_logCtrl_log_end != 64'd0) &&
                          (io_logCtrl_log_begin <= cycle_cnt + 64'd1) &&
                          (cycle_cnt + 64'd1 < io_logCtrl_log_end);
        end
    end

    // Saturating perf counters; clean beats increment, dump captures pre-update values
    always_ff @(posedge clock) begin
        if (!reset) begin
            chars_out      <= '0;
            polls          <= '0;
            snap_chars_out <= '0;
            snap_polls     <= '0;
        end else begin
            if (io_perfInfo_dump) begin
                snap_chars_out <= chars_out;
                snap_polls     <= polls;
            end
            if (io_perfInfo_clean) begin
                chars_out <= '0;
                polls     <= '0;
            end else begin
                if (io_uart_out_valid && (chars_out != '1)) chars_out <= chars_out + PERF_W'(1);
                if (io_uart_in_valid && (polls != '1))      polls     <= polls + PERF_W'(1);
            end
        end
    end

    // Debug-only state observed hierarchically by the harness
    logic unused_debug;
    assign unused_debug = ^{io_logCtrl_log_level[63:1], snap_chars_out, snap_polls, log_active};

endmodule

// File: tb/tb_sim_top.sv
// Self-checking bench for sim_top: boot message timing/content, polling,
// echo, perf counter dump/clean, log window, and reset mid-message.
module tb_sim_top;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] log_begin, log_end, log_level;
    logic        perf_clean, perf_dump;
    logic        out_valid, in_valid, step_out;
    logic [7:0]  out_ch, in_ch;

    int n_vec = 0;
    int n_bad = 0;

    sim_top dut (
        .clock                (clock),
        .reset                (reset),
        .io_logCtrl_log_begin (log_begin),
        .io_logCtrl_log_end   (log_end),
        .io_logCtrl_log_level (log_level),
        .io_perfInfo_clean    (perf_clean),
        .io_perfInfo_dump     (perf_dump),
        .io_uart_out_valid    (out_valid),
        .io_uart_out_ch       (out_ch),
        .io_uart_in_valid     (in_valid),
        .io_uart_in_ch        (in_ch),
        .difftest_step        (step_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ov;
        logic [7:0] ch;
        logic       iv;
        logic       la;
    } vec_t;

    vec_t tbl [0:100];
    logic [7:0] msg [0:13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // e = number of edges since reset release; expectations from the table
    task automatic run_table(input int last);
        for (int e = 1; e <= last; e++) begin
            tick();
            check($sformatf("out_valid@%0d", e), 64'(out_valid), 64'(tbl[e].ov));
            check($sformatf("step@%0d", e), 64'(step_out), 64'(tbl[e].ov));
            check($sformatf("out_ch@%0d", e), 64'(out_ch), 64'(tbl[e].ch));
            check($sformatf("in_valid@%0d", e), 64'(in_valid), 64'(tbl[e].iv));
            check($sformatf("log_active@%0d", e), 64'(dut.log_active), 64'(tbl[e].la));
        end
    endtask

    task automatic wait_poll();
        int i;
        i = 0;
        while (!in_valid && i < 40) begin
            tick();
            i++;
        end
        check("poll_wait_bound", 64'(in_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_ch"}, 64'(out_ch), 64'd0);
        check({tag, "_in_valid"}, 64'(in_valid), 64'd0);
        check({tag, "_step"}, 64'(step_out), 64'd0);
        check({tag, "_cycle"}, dut.cycle_cnt, 64'd0);
    endtask

    initial begin
        logic [7:0] last_ch;

        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

        // Expected per-edge behaviour after release with default parameters
        last_ch = 8'h00;
        for (int e = 0; e <= 100; e++) begin
            tbl[e].ov = (e >= 9) && (e <= 61) && ((e - 9) % 4 == 0);
            if (tbl[e].ov) last_ch = msg[(e - 9) / 4];
            tbl[e].ch = last_ch;
            tbl[e].iv = (e == 77) || (e == 93);
            tbl[e].la = (e >= 10) && (e < 20);
        end

        reset      = 1'b0;
        in_ch      = 8'hFF;
        perf_clean = 1'b0;
        perf_dump  = 1'b0;
        log_begin  = 64'd10;
        log_end    = 64'd20;
        log_level  = 64'd1;

        tick(); tick(); tick();
        check_reset_outputs("reset0");
        check("reset0_chars", 64'(dut.chars_out), 64'd0);
        check("reset0_log", 64'(dut.log_active), 64'd0);

        // Boot message and idle polling
        reset = 1'b1;
        run_table(100);
        check("chars_after_msg", 64'(dut.chars_out), 64'd14);
        check("polls_after_msg", 64'(dut.polls), 64'd2);

        // Snapshot only
        perf_dump = 1'b1;
        tick();
        perf_dump = 1'b0;
        check("snap_chars", 64'(dut.snap_chars_out), 64'd14);
        check("snap_polls", 64'(dut.snap_polls), 64'd2);
        check("chars_kept", 64'(dut.chars_out), 64'd14);

        // Echo of a received byte
        wait_poll();
        in_ch = 8'h41;
        tick();
        check("echo_valid", 64'(out_valid), 64'd1);
        check("echo_ch", 64'(out_ch), 64'h41);
        check("echo_step", 64'(step_out), 64'd1);
        check("echo_in_valid", 64'(in_valid), 64'd0);
        in_ch = 8'hFF;
        tick();
        check("post_echo_valid", 64'(out_valid), 64'd0);
        check("post_echo_hold_ch", 64'(out_ch), 64'h41);
        check("chars_after_echo", 64'(dut.chars_out), 64'd15);
        check("polls_after_echo", 64'(dut.polls), 64'd3);

        // Bytes outside a poll cycle are ignored
        in_ch = 8'h42;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ignore_in_%0d", i), 64'(out_valid), 64'd0);
        end
        in_ch = 8'hFF;

        // Clean and dump together: snapshot old values, counters clear
        perf_clean = 1'b1;
        perf_dump  = 1'b1;
        tick();
        perf_clean = 1'b0;
        perf_dump  = 1'b0;
        check("cd_snap_chars", 64'(dut.snap_chars_out), 64'd15);
        check("cd_snap_polls", 64'(dut.snap_polls), 64'd3);
        check("cd_chars", 64'(dut.chars_out), 64'd0);
        check("cd_polls", 64'(dut.polls), 64'd0);
        wait_poll();
        tick();
        check("resume_polls", 64'(dut.polls), 64'd1);
        check("resume_chars", 64'(dut.chars_out), 64'd0);

        // Log window corner cases
        log_begin = 64'd0;
        log_end   = 64'd100000;
        tick(); tick();
        check("log_wide_on", 64'(dut.log_active), 64'd1);
        log_end = 64'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("log_end0_%0d", i), 64'(dut.log_active), 64'd0);
        end
        log_begin = 64'd300;
        log_end   = 64'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("log_inverted_%0d", i), 64'(dut.log_active), 64'd0);
        end
        log_begin = 64'd10;
        log_end   = 64'd20;
        log_level = 64'd1;

        // Reset mid-message at index 5 (',' emitted on edge 29)
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        run_table(29);
        check("mid_idx5_ch", 64'(out_ch), 64'h2C);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid_rst1");
        tick();
        check_reset_outputs("mid_rst2");
        check("mid_rst_chars", 64'(dut.chars_out), 64'd0);
        reset = 1'b1;
        run_table(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
